fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Read-side client for the synchronous FIFO memory. It pops words from the FIFO's registered-read port (read / dout / empty) and presents them as a valid/ready stream to downstream logic, so consumers never handle FIFO read latency. A 3-entry output buffer sustains one word per cycle with no combinational path from `m_ready` to `fifo_read`. It sits between the FIFO memory and any stream consumer (packetiser, checker, DMA sink).

## Interface
- `DATA_WIDTH`, 8, FIFO word width and stream data width.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; high = fetch from FIFO, low = stop fetching and drain.
- `fifo_read`  out  1  FIFO pop strobe, one word per asserted cycle.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data, valid the cycle after `fifo_read`.
- `fifo_empty`  in  1  FIFO empty flag.
- `m_data`  out  DATA_WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `busy`  out  1  high while not in IDLE.
- `word_count`  out  CNT_WIDTH  words accepted downstream (only with `FIFO_READER_COUNT_EN`).

## Operation
- State machine: IDLE, RUN, DRAIN.
  - IDLE -> RUN when `enable`=1.
  - RUN -> DRAIN when `enable`=0.
  - DRAIN -> RUN when `enable`=1.
  - DRAIN -> IDLE when buffer occupancy = 0 and no read is pending.
- Registers: `occ` (0..3, buffer occupancy) and `pend` (1 when a read was issued last cycle).
- `fifo_read` = (state==RUN) & !`fifo_empty` & (`occ` + `pend` < 3). It depends only on registers and `fifo_empty`.
- A pending word is always captured into the buffer on the cycle after its read, in every state including DRAIN.
- Buffer is in-order. `m_valid` = (`occ` != 0). `m_data` = head entry.
- Pop on `m_valid` & `m_ready`.
- Push and pop in the same cycle leave `occ` unchanged and keep order.
- Overflow is impossible by construction. Assert `occ` ≤ 3 in simulation.
- `m_data` holds its value while `m_valid` & !`m_ready` (standard stream rule: no retraction, no change).
- Reset (any state, including mid-transfer): state IDLE, `occ`=0, `pend`=0, `fifo_read`=0, `m_valid`=0, `m_data`=0, `busy`=0, `word_count`=0. A word in flight from the FIFO is discarded. The FIFO is reset by the same `reset`.

## Timing
- Latency: `fifo_read` in cycle N, data captured at the end of cycle N+1, `m_valid` in cycle N+2.
- Throughput: 1 word/cycle steady state with `m_ready`=1 and the FIFO non-empty. Steady state is `occ`=1, `pend`=1.
- First `fifo_read` comes one cycle after `enable` rises, because the IDLE->RUN transition is registered.
- `enable` low stops `fifo_read` in the following cycle (state registered). At most one more word arrives after that.
- `busy` is registered and falls the cycle after the DRAIN->IDLE condition is met.

## Configuration
- `FIFO_READER_COUNT_EN` defined:
  - `word_count` port exists and increments on each accepted stream beat.
  - It saturates at 2^CNT_WIDTH-1 and clears only on reset.
- Not defined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Structure
- `fifo_stream_reader_pkg`:
  - `BUF_DEPTH` = 3.
  - Occupancy width localparam.
  - State enum `rd_state_e` {IDLE, RUN, DRAIN}.
- Sub-module `fifo_stream_reader_buf`: 3-entry in-order buffer with push/pop/`occ`. The top holds the FSM, read issue and counter.

## Test plan
- Preload 5 words 0x11..0x15, `enable`=1, `m_ready`=1 -> `m_valid` first high 3 cycles after `enable`. 5 consecutive beats 0x11..0x15, then `busy` stays high in RUN.
- Preload 8 words, `m_ready`=0 -> exactly 3 `fifo_read` pulses. `m_data`=first word held stable. Then `m_ready`=1 -> remaining 8 delivered in order at 1/cycle after resumption.
- Stream running, `enable` dropped while `pend`=1 and `occ`=2 -> no further `fifo_read`. 3 more beats delivered, DRAIN->IDLE, `busy`=0.
- FIFO with 1 word, `m_ready`=1 -> single `fifo_read`. `fifo_empty` rises and no read is issued while empty. Writing 0xA5 later -> delivered 2 cycles after its read.
- `reset` asserted with `occ`=2 and `pend`=1 -> next cycle all outputs 0, state IDLE. After reset, fresh data 0x01 delivered and no stale word appears.
- With `FIFO_READER_COUNT_EN`, `CNT_WIDTH`=4 -> after 20 beats `word_count`=15 (saturated).

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Shared sizing and state encoding for the FIFO stream reader.
package fifo_stream_reader_pkg;

   localparam int unsigned BUF_DEPTH = 3;
   localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// In-order output buffer for the stream reader: head at entry 0, shifts on pop,
// push lands behind the last valid entry (after the shift when both happen).
module fifo_stream_reader_buf
   import fifo_stream_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] head_o,
   output logic [OCC_W-1:0]      occ_o
);

   logic [DATA_WIDTH-1:0] ent_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] ent_d [BUF_DEPTH];
   logic [OCC_W-1:0]      occ_q;
   logic [OCC_W-1:0]      occ_d;
   logic [OCC_W-1:0]      wr_idx;
   logic [OCC_W:0]        occ_sum;

   // One extra bit so an overflow or underflow is visible rather than wrapping.
   assign occ_sum = (OCC_W+1)'(occ_q) + (OCC_W+1)'(push_i) - (OCC_W+1)'(pop_i);

   always_comb begin
      ent_d  = ent_q;
      occ_d  = occ_sum[OCC_W-1:0];
      wr_idx = occ_q;
      if (pop_i) begin
         for (int unsigned i = 0; i < BUF_DEPTH - 1; i++) begin
            ent_d[i] = ent_q[i + 1];
         end
         wr_idx = occ_q - OCC_W'(1);
      end
      if (push_i) begin
         ent_d[wr_idx] = push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q <= '0;
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         assert (occ_sum <= (OCC_W+1)'(BUF_DEPTH));
         occ_q <= occ_d;
         ent_q <= ent_d;
      end
   end

   assign head_o = ent_q[0];
   assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a registered-read FIFO and presents the words as a valid/ready stream.
// Optional delivered-word counter enabled by FIFO_READER_COUNT_EN.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   output logic                  fifo_read,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy
`ifdef FIFO_READER_COUNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  word_count
`endif
);

   rd_state_e        state_q;
   rd_state_e        state_d;
   logic             pend_q;
   logic [OCC_W-1:0] occ;
   logic [OCC_W:0]   inflight;
   logic             pop;

   fifo_stream_reader_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk         (clk),
      .reset       (reset),
      .push_i      (pend_q),
      .push_data_i (fifo_dout),
      .pop_i       (pop),
      .head_o      (m_data),
      .occ_o       (occ)
   );

   // Reserve a slot for every word already requested so the buffer never overflows.
   assign inflight  = (OCC_W+1)'(occ) + (OCC_W+1)'(pend_q);
   assign fifo_read = (state_q == RUN) && !fifo_empty && (inflight < (OCC_W+1)'(BUF_DEPTH));
   assign m_valid   = (occ != '0);
   assign pop       = m_valid && m_ready;
   assign busy      = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (!enable) state_d = DRAIN;
         DRAIN: begin
            if (enable) begin
               state_d = RUN;
            end else if ((occ == '0) && !pend_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= fifo_read;
      end
   end

`ifdef FIFO_READER_COUNT_EN
   logic [CNT_WIDTH-1:0] cnt_q;

   // Saturating count of accepted beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (pop && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign word_count = cnt_q;
`else
   logic unused_cnt_width;
   assign unused_cnt_width = ^32'(CNT_WIDTH);
`endif

endmodule
